// File: rtl/sha_msg_sched_if.sv
// Block-in / word-out handshake bundle for the SHA-2 message scheduler.
// The master modport is the scheduler side; the slave modport is the block source and round core.
interface sha_msg_sched_if #(
  parameter int WORD_W = 32,
  parameter int IDX_W  = 7
);
  logic                  blk_valid;
  logic                  blk_ready;
  logic [16*WORD_W-1:0]  blk_data;
  logic                  w_valid;
  logic                  w_ready;
  logic [WORD_W-1:0]     w_data;
  logic [IDX_W-1:0]      w_index;
  logic                  w_last;

  modport master (
    input  blk_valid, blk_data, w_ready,
    output blk_ready, w_valid, w_data, w_index, w_last
  );

  modport slave (
    output blk_valid, blk_data, w_ready,
    input  blk_ready, w_valid, w_data, w_index, w_last
  );
endinterface

// File: rtl/sha_msg_sched_stream.sv
// SHA-256/SHA-512 message scheduler streaming W[0..ROUNDS-1] from a rolling 16-word window.
// Optional macro SHA_MSG_SCHED_BACK2BACK_EN lets a new block load on the final word handshake.
module sha_msg_sched_stream #(
  parameter int WORD_W = 32,
  parameter int IDX_W  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  sha_msg_sched_if.master       bus,
  output logic                  busy
);

  localparam int ROUNDS = (WORD_W == 64) ? 80 : 64;
  localparam logic [IDX_W-1:0] PRE_LAST_T = IDX_W'(ROUNDS - 2);

  if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
    $error("sha_msg_sched_stream: WORD_W must be 32 or 64");
  end

  // Sigma rotate/shift amounts for the selected hash width.
  localparam int S0_A = (WORD_W == 32) ? 7  : 1;
  localparam int S0_B = (WORD_W == 32) ? 18 : 8;
  localparam int S0_C = (WORD_W == 32) ? 3  : 7;
  localparam int S1_A = (WORD_W == 32) ? 17 : 19;
  localparam int S1_B = (WORD_W == 32) ? 19 : 61;
  localparam int S1_C = (WORD_W == 32) ? 10 : 6;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    return rotr(x, S0_A) ^ rotr(x, S0_B) ^ (x >> S0_C);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    return rotr(x, S1_A) ^ rotr(x, S1_B) ^ (x >> S1_C);
  endfunction

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [WORD_W-1:0]  win [16];
  logic [IDX_W-1:0]   t;
  logic               blk_ready_q;
  logic               w_valid_q;
  logic               w_last_q;
  logic               busy_q;
  logic [WORD_W-1:0]  next_word;
  logic               load_en;
  logic               shift_en;

`ifdef SHA_MSG_SCHED_BACK2BACK_EN
  // The final word's handshake frees the window, so the next block may load on that same edge.
  assign bus.blk_ready = blk_ready_q | (w_last_q & bus.w_ready);
`else
  assign bus.blk_ready = blk_ready_q;
`endif

  assign load_en   = bus.blk_valid & bus.blk_ready;
  assign shift_en  = w_valid_q & bus.w_ready;
  assign next_word = win[0] + sig0(win[1]) + win[9] + sig1(win[14]);

  assign bus.w_valid = w_valid_q;
  assign bus.w_data  = win[0];
  assign bus.w_index = t;
  assign bus.w_last  = w_last_q;
  assign busy        = busy_q;

  // NOTE: the window is plain flops and is cleared on reset so w_data reads 0 afterwards;
  // a RAM-style array would normally be left unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (load_en) begin
      for (int i = 0; i < 16; i++) win[i] <= bus.blk_data[16*WORD_W-1-WORD_W*i -: WORD_W];
    end else if (shift_en) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= next_word;
    end
  end

  // NOTE: all state and outputs use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      blk_ready_q <= 1'b1;
      w_valid_q   <= 1'b0;
      w_last_q    <= 1'b0;
      busy_q      <= 1'b0;
      t           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_en) begin
            state       <= RUN;
            blk_ready_q <= 1'b0;
            w_valid_q   <= 1'b1;
            busy_q      <= 1'b1;
            w_last_q    <= 1'b0;
            t           <= '0;
          end
        end
        RUN: begin
          if (shift_en) begin
            if (w_last_q) begin
              t        <= '0;
              w_last_q <= 1'b0;
              if (!load_en) begin
                state       <= IDLE;
                blk_ready_q <= 1'b1;
                w_valid_q   <= 1'b0;
                busy_q      <= 1'b0;
              end
            end else begin
              t        <= t + 1'b1;
              w_last_q <= (t == PRE_LAST_T);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_msg_sched_stream.sv
// Scoreboard bench for sha_msg_sched_stream: SHA-256 and SHA-512 instances side by side,
// expected words come from a full-array software schedule plus hand-computed vectors.
module tb_sha_msg_sched_stream;

  typedef struct {
    logic [63:0] data;
    int          idx;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic busy32, busy64;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp32[$];
  exp_t exp64[$];

  always #5 clk = ~clk;

  sha_msg_sched_if #(.WORD_W(32), .IDX_W(7)) if32 ();
  sha_msg_sched_if #(.WORD_W(64), .IDX_W(7)) if64 ();

  sha_msg_sched_stream #(.WORD_W(32), .IDX_W(7)) u_dut32 (
    .clk (clk), .rst (rst), .bus (if32.master), .busy (busy32)
  );
  sha_msg_sched_stream #(.WORD_W(64), .IDX_W(7)) u_dut64 (
    .clk (clk), .rst (rst), .bus (if64.master), .busy (busy64)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference schedule: straightforward 64/80-entry array, no rolling window.
  function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction
  function automatic logic [31:0] s0_32(input logic [31:0] x);
    return rotr32(x, 7) ^ rotr32(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] s1_32(input logic [31:0] x);
    return rotr32(x, 17) ^ rotr32(x, 19) ^ (x >> 10);
  endfunction
  function automatic logic [63:0] s0_64(input logic [63:0] x);
    return rotr64(x, 1) ^ rotr64(x, 8) ^ (x >> 7);
  endfunction
  function automatic logic [63:0] s1_64(input logic [63:0] x);
    return rotr64(x, 19) ^ rotr64(x, 61) ^ (x >> 6);
  endfunction

  task automatic push_block(input bit wide, input logic [1023:0] blk);
    logic [63:0] w [80];
    logic [31:0] tmp;
    int          n;
    exp_t        e;
    n = wide ? 80 : 64;
    for (int i = 0; i < 16; i++)
      w[i] = wide ? blk[1023-64*i -: 64] : {32'b0, blk[511-32*i -: 32]};
    for (int i = 16; i < n; i++) begin
      if (wide) begin
        w[i] = s1_64(w[i-2]) + w[i-7] + s0_64(w[i-15]) + w[i-16];
      end else begin
        tmp  = s1_32(w[i-2][31:0]) + w[i-7][31:0] + s0_32(w[i-15][31:0]) + w[i-16][31:0];
        w[i] = {32'b0, tmp};
      end
    end
    for (int i = 0; i < n; i++) begin
      e.data = w[i];
      e.idx  = i;
      e.last = (i == n - 1);
      if (wide) exp64.push_back(e);
      else      exp32.push_back(e);
    end
  endtask

  // Monitors: pop on every word handshake, and check hold-stability across stalls.
  logic        stall32 = 1'b0, stall64 = 1'b0;
  logic [63:0] held_data32, held_data64;
  logic [6:0]  held_idx32, held_idx64;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall32 = 1'b0;
    end else if (if32.w_valid) begin
      if (stall32) begin
        check("stall_data32", 64'(if32.w_data), held_data32);
        check("stall_index32", 64'(if32.w_index), 64'(held_idx32));
      end
      if (if32.w_ready) begin
        stall32 = 1'b0;
        if (exp32.size() == 0) begin
          check("unexpected_word32", 64'(if32.w_index), 64'hFFFF);
        end else begin
          e = exp32.pop_front();
          check("w_data32", 64'(if32.w_data), e.data);
          check("w_index32", 64'(if32.w_index), 64'(e.idx));
          check("w_last32", 64'(if32.w_last), 64'(e.last));
        end
      end else begin
        stall32     = 1'b1;
        held_data32 = 64'(if32.w_data);
        held_idx32  = if32.w_index;
      end
    end else begin
      stall32 = 1'b0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall64 = 1'b0;
    end else if (if64.w_valid) begin
      if (stall64) begin
        check("stall_data64", if64.w_data, held_data64);
        check("stall_index64", 64'(if64.w_index), 64'(held_idx64));
      end
      if (if64.w_ready) begin
        stall64 = 1'b0;
        if (exp64.size() == 0) begin
          check("unexpected_word64", 64'(if64.w_index), 64'hFFFF);
        end else begin
          e = exp64.pop_front();
          check("w_data64", if64.w_data, e.data);
          check("w_index64", 64'(if64.w_index), 64'(e.idx));
          check("w_last64", 64'(if64.w_last), 64'(e.last));
        end
      end else begin
        stall64     = 1'b1;
        held_data64 = if64.w_data;
        held_idx64  = if64.w_index;
      end
    end else begin
      stall64 = 1'b0;
    end
  end

  // Offer one block, stream it to completion, then confirm the return to IDLE.
  task automatic send(input bit wide, input logic [1023:0] blk, input bit rand_ready,
                      input int exp_cycles);
    int   cycles;
    logic done;
    logic rdy;
    if (wide) begin
      if64.blk_data = blk; if64.blk_valid = 1'b1; if64.w_ready = 1'b1;
    end else begin
      if32.blk_data = blk[511:0]; if32.blk_valid = 1'b1; if32.w_ready = 1'b1;
    end
    done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      done = wide ? if64.blk_ready : if32.blk_ready;
      @(posedge clk); #1;
    end
    if (wide) if64.blk_valid = 1'b0;
    else      if32.blk_valid = 1'b0;
    if (!done) begin
      check("block_accept", 64'(done), 64'd1);
      return;
    end
    cycles = 1;
    done   = 1'b0;
    for (int k = 0; k < 2000 && !done; k++) begin
      rdy = rand_ready ? ($urandom_range(0, 9) >= 3) : 1'b1;
      if (wide) if64.w_ready = rdy;
      else      if32.w_ready = rdy;
      @(negedge clk);
      cycles++;
      done = wide ? (if64.w_valid && if64.w_ready && if64.w_last)
                  : (if32.w_valid && if32.w_ready && if32.w_last);
      @(posedge clk); #1;
    end
    check("stream_end", 64'(done), 64'd1);
    if (!rand_ready) check("block_cycles", 64'(cycles), 64'(exp_cycles));
    @(negedge clk);
    check("idle_ready", 64'(wide ? if64.blk_ready : if32.blk_ready), 64'd1);
    check("idle_valid", 64'(wide ? if64.w_valid : if32.w_valid), 64'd0);
    check("idle_busy",  64'(wide ? busy64 : busy32), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1023:0] abc32, abc64, blk_c, blk_d;
    logic          aborted, ign_seen, acc;
    int            phase, valid_cnt, gap;

    abc32 = {512'b0, 32'h61626380, 448'b0, 32'h00000018};
    abc64 = {64'h6162638000000000, 896'b0, 64'h18};
    blk_c = '0;
    for (int i = 0; i < 16; i++) blk_c[511-32*i -: 32] = 32'h9e3779b9 * (i + 1);
    blk_d = {512'b0, ~blk_c[511:0]};

    rst = 1'b1;
    if32.blk_valid = 1'b0; if32.blk_data = '0; if32.w_ready = 1'b0;
    if64.blk_valid = 1'b0; if64.blk_data = '0; if64.w_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_blk_ready", 64'(if32.blk_ready), 64'd1);
    check("rst_w_valid",   64'(if32.w_valid), 64'd0);
    check("rst_busy",      64'(busy32), 64'd0);
    check("rst_w_index",   64'(if32.w_index), 64'd0);
    check("rst_w_data",    64'(if32.w_data), 64'd0);
    check("rst_blk_ready64", 64'(if64.blk_ready), 64'd1);
    check("rst_w_valid64",   64'(if64.w_valid), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // SHA-256 "abc": hand-derived W16..W18 anchor the model.
    push_block(1'b0, abc32);
    check("model_w16_32", exp32[16].data, 64'h61626380);
    check("model_w17_32", exp32[17].data, 64'h000F0000);
    check("model_w18_32", exp32[18].data, 64'h7DA86405);
    send(1'b0, abc32, 1'b0, 65);

    // SHA-512 "abc".
    push_block(1'b1, abc64);
    check("model_w16_64", exp64[16].data, 64'h6162638000000000);
    check("model_w17_64", exp64[17].data, 64'h00030000000000C0);
    send(1'b1, abc64, 1'b0, 81);

    // Random backpressure, ~30% stall cycles.
    push_block(1'b0, abc32);
    send(1'b0, abc32, 1'b1, 0);

    // Block offered mid-stream is ignored; reset at word 40 aborts the block.
    push_block(1'b0, blk_c);
    if32.blk_data = blk_c[511:0]; if32.blk_valid = 1'b1; if32.w_ready = 1'b1;
    @(negedge clk);
    check("c_accept", 64'(if32.blk_ready), 64'd1);
    @(posedge clk); #1;
    if32.blk_valid = 1'b0;
    aborted  = 1'b0;
    ign_seen = 1'b0;
    for (int k = 0; k < 200 && !aborted; k++) begin
      if (if32.w_valid && if32.w_index == 7'd20) begin
        if32.blk_data = blk_d[511:0]; if32.blk_valid = 1'b1;
      end else begin
        if32.blk_valid = 1'b0;
      end
      if (if32.w_valid && if32.w_index == 7'd40) begin
        rst = 1'b1; aborted = 1'b1;
      end
      @(negedge clk);
      if (if32.blk_valid) begin
        ign_seen = 1'b1;
        check("ignore_blk_ready", 64'(if32.blk_ready), 64'd0);
      end
      @(posedge clk); #1;
    end
    if32.blk_valid = 1'b0;
    check("ignore_pulse_seen", 64'(ign_seen), 64'd1);
    check("abort_reached", 64'(aborted), 64'd1);
    check("abort_w_valid", 64'(if32.w_valid), 64'd0);
    check("abort_busy",    64'(busy32), 64'd0);
    check("abort_w_index", 64'(if32.w_index), 64'd0);
    check("abort_w_last",  64'(if32.w_last), 64'd0);
    check("abort_blk_ready", 64'(if32.blk_ready), 64'd1);
    exp32.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    push_block(1'b0, blk_c);
    send(1'b0, blk_c, 1'b0, 65);

    // Two blocks offered continuously: count bubbles between them.
    push_block(1'b0, abc32);
    push_block(1'b0, blk_c);
    if32.w_ready = 1'b1; if32.blk_data = abc32[511:0]; if32.blk_valid = 1'b1;
    phase = 0; valid_cnt = 0; gap = 0;
    for (int k = 0; k < 600 && valid_cnt < 128; k++) begin
      @(negedge clk);
      if (if32.w_valid) valid_cnt++;
      else if (valid_cnt > 0) gap++;
      acc = if32.blk_valid && if32.blk_ready;
      @(posedge clk); #1;
      if (acc) begin
        if (phase == 0) begin
          if32.blk_data = blk_c[511:0]; phase = 1;
        end else begin
          if32.blk_valid = 1'b0; phase = 2;
        end
      end
    end
    if32.blk_valid = 1'b0;
    check("b2b_valid_cycles", 64'(valid_cnt), 64'd128);
    check("b2b_both_loaded", 64'(phase), 64'd2);
`ifdef SHA_MSG_SCHED_BACK2BACK_EN
    check("b2b_gap", 64'(gap), 64'd0);
`else
    check("b2b_gap", 64'(gap), 64'd1);
`endif

    repeat (4) @(negedge clk);
    check("final_idle32", 64'(if32.blk_ready), 64'd1);
    check("drain32", 64'(exp32.size()), 64'd0);
    check("drain64", 64'(exp64.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sha_msg_sched_stream.md
Name: sha_msg_sched_stream

Overview:
- Sequential, parametrised message scheduler for the SHA-2 family. It accepts one padded message block per handshake and streams the expanded words W[0..ROUNDS-1] one per cycle to the round core.
- Uses a rolling 16-word window instead of a full 64-word array, which cuts storage to 16 words and removes the wide combinational chain.
- WORD_W selects SHA-256 (32-bit words, 64 rounds) or SHA-512 (64-bit words, 80 rounds).
- Sits between the padding/block buffer and the compression round core.

Parameters:
- WORD_W, 32, word width. Only 32 (SHA-256) or 64 (SHA-512) is legal; any other value fails elaboration.
- ROUNDS, derived (64 when WORD_W=32, 80 when WORD_W=64), number of words emitted per block. Localparam, not overridable.
- IDX_W, 7, width of w_index.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- blk_valid  in  1  input block offered.
- blk_ready  out  1  scheduler can accept a block.
- blk_data  in  16*WORD_W  block; word 0 in the MSBs (W[i] = blk_data[16*WORD_W-1-WORD_W*i -: WORD_W]).
- w_valid  out  1  w_data/w_index valid.
- w_ready  in  1  round core accepts word.
- w_data  out  WORD_W  current word W[t].
- w_index  out  IDX_W  t, 0..ROUNDS-1.
- w_last  out  1  high with w_valid when t = ROUNDS-1.
- busy  out  1  high in RUN state.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high. Reset values: state=IDLE, blk_ready=1, w_valid=0, w_last=0, busy=0, w_index=0, w_data=0, all 16 window registers 0.
- States: IDLE and RUN.
- IDLE:
  - blk_ready=1, w_valid=0.
  - On blk_valid&&blk_ready: load win[i]=W[i] for i=0..15, t=0, go to RUN.
  - No words appear in the load cycle; w_valid rises the next cycle, so latency is 1 cycle.
- RUN outputs:
  - w_valid=1, w_data=win[0], w_index=t, w_last=(t==ROUNDS-1).
  - blk_ready=0, except under the optional feature.
- RUN word handshake (w_valid&&w_ready):
  - win[i] <= win[i+1] for i=0..14.
  - win[15] <= win[0] + s0(win[1]) + win[9] + s1(win[14]), all addition mod 2^WORD_W.
  - t <= t+1.
  - Window words computed past ROUNDS-1 are never emitted; this is legal.
- Sigma functions (rotr = rotate right, shr = logical shift right):
  - WORD_W=32: s0(x) = rotr7 ^ rotr18 ^ shr3; s1(x) = rotr17 ^ rotr19 ^ shr10.
  - WORD_W=64: s0(x) = rotr1 ^ rotr8 ^ shr7; s1(x) = rotr19 ^ rotr61 ^ shr6.
- Backpressure: while w_valid && !w_ready, w_data, w_index and w_last hold stable and the window does not shift.
- Block end: handshake with w_last=1 -> IDLE (base build), t reset to 0.
- blk_valid in RUN is ignored: blk_ready=0 and blk_data is not sampled.
- Reset mid-block: current block is discarded, all outputs return to reset values next cycle, and no partial words are emitted afterwards.
- Throughput, base build: ROUNDS+1 cycles per block with continuous w_ready (1 load cycle plus ROUNDS word cycles).

Optional Feature:
- Macro: SHA_MSG_SCHED_BACK2BACK_EN.
- Defined:
  - In RUN, blk_ready = w_last && w_ready.
  - If blk_valid is also high in that cycle, the new block loads into the window in the same edge as the final word handshake, and the state stays RUN with t=0.
  - No bubble between blocks; sustained throughput is ROUNDS cycles per block.
- Undefined:
  - blk_ready=0 throughout RUN.
  - Mandatory one IDLE cycle between blocks.

Test Plan:
- Reset: assert rst 2 cycles -> blk_ready=1, w_valid=0, busy=0, w_index=0.
- SHA-256 vector: WORD_W=32, padded "abc" block (W0=0x61626380, W15=0x00000018, rest 0), w_ready=1.
  - W16=0x61626380, W17=0x000F0000, W18=0x7DA86405.
  - All 64 words match the software model.
  - w_last only at w_index=63.
  - 65 cycles from load to IDLE.
- SHA-512 vector: WORD_W=64, W0=0x6162638000000000, W15=0x18.
  - W16=0x6162638000000000, W17=0x00030000000000C0.
  - All 80 words match the software model; w_last at index 79.
- Backpressure: random w_ready at 30% -> word sequence is identical to the no-stall run, and w_data/w_index are stable during every stall.
- Busy ignore and reset abort:
  - blk_valid pulsed with a different block at t=20 -> ignored, the stream is unchanged.
  - rst asserted at t=40 -> w_valid=0 next cycle; a following block streams correctly from W0.
- Back-to-back: with SHA_MSG_SCHED_BACK2BACK_EN defined, two blocks offered continuously -> the second block's W0 follows the first block's W63 with no gap (128 consecutive w_valid cycles). Undefined -> exactly 1 gap cycle.
